// File: rtl/fetch_pkg.sv
// Shared fetch-stage encodings and defaults.
package fetch_pkg;

   typedef enum logic [1:0] {
      FS_RUN   = 2'd0,
      FS_FLUSH = 2'd1,
      FS_HALT  = 2'd2
   } fetch_state_t;

   localparam int unsigned IRQ_VECTOR_DEFAULT = 32'h0000_0010;
   localparam int          FETCH_CNT_W        = 32;

endpackage

// File: rtl/fetch_unit_param_perf_counter.sv
// Wrapping up-counter with enable and synchronous active-low clear.
// Count visible one cycle after enable; no backpressure.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit_param.sv
// Fetch stage: PC sequencing, branch/irq redirect, halt/resume, cycle counter; FETCH_PERF_CNT_EN adds fetch_count.
// Redirect -> new pc next cycle, fetch_valid two cycles later; fetch_ready low holds pc with fetch_valid kept high.
module fetch_unit_param
   import fetch_pkg::*;
#(
   parameter int          ADDR_W     = 16,
   parameter int          CNT_W      = FETCH_CNT_W,
   parameter int unsigned RESET_PC   = 0,
   parameter int unsigned IRQ_VECTOR = IRQ_VECTOR_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fetch_ready,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_address,
   input  logic              irq_req,
   input  logic              halt_req,
   input  logic              resume,
   input  logic              cc_enable,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_next_seq,
   output logic              fetch_valid,
   output logic [ADDR_W-1:0] epc,
   output logic [1:0]        fsm_state,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  fetch_count
);

   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] IRQ_ADDR   = ADDR_W'(IRQ_VECTOR);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic              redirect;

   assign redirect    = irq_req | branch_taken;
   assign pc_next_seq = pc_q + ADDR_W'(1);
   assign pc          = pc_q;
   assign epc         = epc_q;
   assign fsm_state   = state_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= FS_RUN;
         pc_q    <= RESET_ADDR;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
      end
   end

   // A redirect always wins; halt_req raised alongside one is dropped.
   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = FS_FLUSH;
      end else begin
         case (state_q)
            FS_RUN:   if (halt_req) state_d = FS_HALT;
            FS_FLUSH: state_d = halt_req ? FS_HALT : FS_RUN;
            FS_HALT:  if (resume && !halt_req) state_d = FS_RUN;
            default:  state_d = FS_RUN;
         endcase
      end
   end

   always_comb begin
      fetch_valid = (state_q == FS_RUN) && !redirect;
      pc_d        = pc_q;
      epc_d       = epc_q;
      if (irq_req) begin
         pc_d  = IRQ_ADDR;
         epc_d = pc_q;
      end else if (branch_taken) begin
         pc_d = branch_address;
      end else if (state_q == FS_RUN && !halt_req && fetch_ready) begin
         pc_d = pc_next_seq;
      end
   end

   perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clock  (clock),
      .reset  (reset),
      .enable (cc_enable),
      .count  (cycle_count)
   );

`ifdef FETCH_PERF_CNT_EN
   perf_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
      .clock  (clock),
      .reset  (reset),
      .enable (fetch_valid & fetch_ready),
      .count  (fetch_count)
   );
`else
   assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit_param.sv
// Directed bench for fetch_unit_param with queue scoreboard; counters built 8 bits wide to reach wrap quickly.
module tb_fetch_unit_param;

   localparam logic [1:0] R = 2'd0, F = 2'd1, H = 2'd2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_ready = 1'b0, branch_taken = 1'b0, irq_req = 1'b0;
   logic        halt_req = 1'b0, resume = 1'b0, cc_enable = 1'b1;
   logic [15:0] branch_address = '0;
   logic [15:0] pc, pc_next_seq, epc;
   logic        fetch_valid;
   logic [1:0]  fsm_state;
   logic [7:0]  cycle_count, fetch_count;

   fetch_unit_param #(
      .ADDR_W(16), .CNT_W(8), .RESET_PC(0), .IRQ_VECTOR(32'h10)
   ) dut (
      .clock(clock), .reset(reset), .fetch_ready(fetch_ready),
      .branch_taken(branch_taken), .branch_address(branch_address),
      .irq_req(irq_req), .halt_req(halt_req), .resume(resume),
      .cc_enable(cc_enable), .pc(pc), .pc_next_seq(pc_next_seq),
      .fetch_valid(fetch_valid), .epc(epc), .fsm_state(fsm_state),
      .cycle_count(cycle_count), .fetch_count(fetch_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] pc;
      logic        vld;
      logic [1:0]  st;
      logic [15:0] epc;
      logic        chk;
      logic [7:0]  cc;
      logic [7:0]  fc;
      int          idx;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   step_no = 0;

   function automatic int fc_exp(input int n);
`ifdef FETCH_PERF_CNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   // Monitor: pops one expectation per cycle, away from the active edge.
   always @(negedge clock) begin
      if (q.size() > 0) begin
         exp_t        e;
         logic [15:0] nx;
         e  = q.pop_front();
         nx = e.pc + 16'd1;
         cmp("pc",          e.idx, 32'(pc),          32'(e.pc));
         cmp("pc_next_seq", e.idx, 32'(pc_next_seq), 32'(nx));
         cmp("fetch_valid", e.idx, 32'(fetch_valid), 32'(e.vld));
         cmp("fsm_state",   e.idx, 32'(fsm_state),   32'(e.st));
         cmp("epc",         e.idx, 32'(epc),         32'(e.epc));
         if (e.chk) begin
            cmp("cycle_count", e.idx, 32'(cycle_count), 32'(e.cc));
            cmp("fetch_count", e.idx, 32'(fetch_count), 32'(e.fc));
         end
      end
   end

   task automatic step(input logic rdy, input logic br, input logic [15:0] ba,
                       input logic irq, input logic halt, input logic res,
                       input logic [15:0] e_pc, input logic e_vld, input logic [1:0] e_st,
                       input logic [15:0] e_epc,
                       input logic chk = 1'b0, input int ecc = 0, input int efc = 0);
      exp_t e;
      fetch_ready    = rdy;
      branch_taken   = br;
      branch_address = ba;
      irq_req        = irq;
      halt_req       = halt;
      resume         = res;
      step_no++;
      e.pc  = e_pc;  e.vld = e_vld; e.st = e_st; e.epc = e_epc;
      e.chk = chk;   e.cc  = 8'(ecc); e.fc = 8'(efc); e.idx = step_no;
      q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      fetch_ready = 1'b0; branch_taken = 1'b0; irq_req = 1'b0;
      halt_req = 1'b0; resume = 1'b0; cc_enable = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      // Sequential fetch, halt with wake by irq, resume.
      do_reset();
      step(1,0,0,0,0,0, 16'h0000,1,R,16'h0000, 1, 0, 0);
      step(1,0,0,0,0,0, 16'h0001,1,R,16'h0000);
      step(1,0,0,0,0,0, 16'h0002,1,R,16'h0000);
      step(1,0,0,0,0,0, 16'h0003,1,R,16'h0000);
      step(1,0,0,0,0,0, 16'h0004,1,R,16'h0000);
      step(0,0,0,0,0,0, 16'h0005,1,R,16'h0000, 1, 5, fc_exp(5));
      step(0,0,0,0,1,0, 16'h0005,1,R,16'h0000);
      step(1,0,0,0,0,0, 16'h0005,0,H,16'h0000);
      step(0,0,0,0,1,1, 16'h0005,0,H,16'h0000);
      step(1,0,0,0,0,0, 16'h0005,0,H,16'h0000);
      step(0,0,0,0,0,0, 16'h0005,0,H,16'h0000);
      step(0,0,0,1,0,0, 16'h0005,0,H,16'h0000);
      step(1,0,0,0,0,0, 16'h0010,0,F,16'h0005);
      step(1,0,0,0,0,0, 16'h0010,1,R,16'h0005);
      step(0,0,0,0,0,0, 16'h0011,1,R,16'h0005, 1, 14, fc_exp(6));
      step(0,0,0,0,1,0, 16'h0011,1,R,16'h0005);
      step(1,0,0,0,0,0, 16'h0011,0,H,16'h0005);
      step(0,0,0,0,0,1, 16'h0011,0,H,16'h0005);
      step(1,0,0,0,0,0, 16'h0011,1,R,16'h0005);
      step(0,0,0,0,0,0, 16'h0012,1,R,16'h0005);

      // Stall, branch, halt dropped on redirect, irq beats branch, branch out of HALT.
      do_reset();
      step(1,0,0,0,0,0, 16'h0000,1,R,16'h0000, 1, 0, 0);
      step(1,0,0,0,0,0, 16'h0001,1,R,16'h0000);
      step(1,0,0,0,0,0, 16'h0002,1,R,16'h0000);
      step(0,0,0,0,0,0, 16'h0003,1,R,16'h0000);
      step(0,0,0,0,0,0, 16'h0003,1,R,16'h0000);
      step(0,0,0,0,0,0, 16'h0003,1,R,16'h0000);
      step(1,0,0,0,0,0, 16'h0003,1,R,16'h0000);
      step(1,0,0,0,0,0, 16'h0004,1,R,16'h0000);
      step(1,0,0,0,0,0, 16'h0005,1,R,16'h0000);
      step(1,0,0,0,0,0, 16'h0006,1,R,16'h0000);
      step(1,1,16'h0040,0,0,0, 16'h0007,0,R,16'h0000);
      step(1,0,0,0,0,0, 16'h0040,0,F,16'h0000);
      step(1,0,0,0,0,0, 16'h0040,1,R,16'h0000);
      step(0,0,0,0,0,0, 16'h0041,1,R,16'h0000, 1, 13, fc_exp(8));
      step(0,1,16'h0020,0,1,0, 16'h0041,0,R,16'h0000);
      step(0,0,0,0,0,0, 16'h0020,0,F,16'h0000);
      step(1,0,0,0,0,0, 16'h0020,1,R,16'h0000);
      step(1,1,16'h0080,1,0,0, 16'h0021,0,R,16'h0000);
      step(0,0,0,0,1,0, 16'h0010,0,F,16'h0021);
      step(0,0,0,0,0,0, 16'h0010,0,H,16'h0021);
      step(0,1,16'h0030,0,0,0, 16'h0010,0,H,16'h0021);
      step(0,0,0,0,0,0, 16'h0030,0,F,16'h0021);
      step(0,0,0,0,0,0, 16'h0030,1,R,16'h0021);
      step(0,1,16'hFFFE,0,0,0, 16'h0030,0,R,16'h0021);

      // Reset lands while in FLUSH; then pc wraps at 0xFFFF.
      do_reset();
      step(0,0,0,0,0,0, 16'h0000,1,R,16'h0000, 1, 0, 0);
      step(0,1,16'hFFFE,0,0,0, 16'h0000,0,R,16'h0000);
      step(1,0,0,0,0,0, 16'hFFFE,0,F,16'h0000);
      step(1,0,0,0,0,0, 16'hFFFE,1,R,16'h0000);
      step(1,0,0,0,0,0, 16'hFFFF,1,R,16'h0000);
      step(0,0,0,0,0,0, 16'h0000,1,R,16'h0000, 1, 5, fc_exp(2));

      // Cycle counter wrap 0xFF -> 0x00, then hold with cc_enable low.
      do_reset();
      for (int i = 0; i < 263; i++) begin
         int  ecc;
         logic chk;
         cc_enable = (i < 258);
         ecc = (i <= 258) ? (i % 256) : 2;
         chk = (i == 0) || (i == 255) || (i == 256) || (i == 258) || (i == 262);
         step(0,0,0,0,0,0, 16'h0000,1,R,16'h0000, chk, ecc, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit_param.md
Name: fetch_unit_param

Overview:
- Parametrised instruction-fetch stage for the simple pipeline.
- Holds the program counter and sequences it. Redirects on taken branches and on interrupts to a fixed vector.
- Supports halt/resume and stalls via a valid/ready handshake to decode.
- Keeps a free-running cycle counter. An optional fetch counter provides performance measurement.

Parameters:
- ADDR_W, 16, width of program counter and all addresses.
- CNT_W, 32, width of cycle and fetch counters.
- RESET_PC, 0, PC value loaded on reset.
- IRQ_VECTOR, 16'h0010, PC loaded on interrupt entry; truncated/zero-extended to ADDR_W.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- fetch_ready  in  1  decode accepts the current fetch.
- branch_taken  in  1  redirect request from execute.
- branch_address  in  ADDR_W  branch target.
- irq_req  in  1  interrupt request, level.
- halt_req  in  1  stop fetching.
- resume  in  1  leave HALT.
- cc_enable  in  1  cycle counter increment enable.
- pc  out  ADDR_W  current fetch address (registered).
- pc_next_seq  out  ADDR_W  pc+1, combinational.
- fetch_valid  out  1  pc is a valid fetch this cycle.
- epc  out  ADDR_W  return address saved on interrupt entry.
- fsm_state  out  2  RUN=0, FLUSH=1, HALT=2.
- cycle_count  out  CNT_W  cycle counter.
- fetch_count  out  CNT_W  accepted-fetch counter (see Optional Feature).

Behaviour:
- Reset (reset==0 at posedge) has priority over everything. Reset values:
  - pc=RESET_PC, epc=0, fsm_state=RUN.
  - cycle_count=0, fetch_count=0.
  - Reset mid-operation discards any pending redirect or halt.
- fetch_valid = (fsm_state==RUN) && !branch_taken && !irq_req (combinational).
- pc_next_seq = pc+1 mod 2^ADDR_W. 0xFFFF wraps to 0x0000 at ADDR_W=16.
- Next-PC priority per cycle, highest first:
  1. irq_req: pc<=IRQ_VECTOR, epc<=pc, state<=FLUSH.
  2. branch_taken: pc<=branch_address, state<=FLUSH.
  3. In RUN with halt_req: pc held, state<=HALT.
  4. In RUN with fetch_ready: pc<=pc_next_seq.
  5. Otherwise pc held. A stall holds pc and fetch_valid stays 1.
- irq and branch are accepted in any state, including FLUSH and HALT.
  - irq in HALT wakes the core (HALT->FLUSH).
  - Simultaneous irq+branch: irq wins. epc records the pre-redirect pc; the branch is dropped.
- FLUSH lasts exactly one cycle:
  - fetch_valid=0, pc held.
  - Next state is RUN, or HALT if halt_req is high that cycle.
- HALT: fetch_valid=0, pc held. resume=1 -> RUN next cycle. halt_req and resume both high in HALT -> stays HALT.
- halt_req coinciding with branch/irq is ignored; the requester must re-assert it.
- cycle_count: +1 per cycle when cc_enable=1, held otherwise. Wraps at 2^CNT_W-1 -> 0.
- Latency: redirect request at cycle N -> new pc visible N+1, fetch_valid=1 at N+2.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: fetch_count increments when fetch_valid && fetch_ready, wraps like cycle_count, and resets to 0.
- Undefined: no counter register; fetch_count tied to 0.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding constants FS_RUN, FS_FLUSH, FS_HALT (2 bits);
  - default IRQ_VECTOR constant;
  - counter width constant.
- One natural sub-module, perf_counter (CNT_W, enable input, synchronous active-low reset, wrap). It is instantiated for cycle_count and, under the macro, for fetch_count.

Test Plan:
- Reset then fetch_ready=1 for 5 cycles -> pc 0,1,2,3,4,5; fetch_valid=1 throughout; cycle_count=5 with cc_enable=1.
- fetch_ready=0 at pc=3 for 3 cycles -> pc stays 3, fetch_valid=1. Release -> pc=4.
- branch_taken with branch_address=0x0040 at pc=7 -> next cycle pc=0x0040 in FLUSH with fetch_valid=0, then RUN with fetch_valid=1.
- irq_req and branch_taken together at pc=0x0021 -> pc=0x0010, epc=0x0021, branch ignored.
- halt_req at pc=5 -> HALT, pc=5, fetch_valid=0 for 4 cycles. irq_req wakes -> pc=0x0010, epc=5. Separately, resume from HALT -> RUN at pc=5.
- Boundary: pc=0xFFFF with fetch_ready -> pc=0x0000. Preload cycle_count near max (CNT_W=8 build) -> 0xFF to 0x00. With FETCH_PERF_CNT_EN, fetch_count counts only handshaked cycles; without it, fetch_count=0. Reset mid-FLUSH -> pc=RESET_PC, state RUN.
